// File: rtl/gouram_trace_pkg.sv
// gouram_trace_pkg: shared trace record, pending-entry and memory FSM types
package gouram_trace_pkg;

    localparam int TRACE_IDW = 32;
    localparam int TRACE_IAW = 16;
    localparam int TRACE_DAW = 32;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} mem_state_e;

    typedef struct packed {
        logic [TRACE_IDW-1:0] instruction;
        logic [TRACE_IAW-1:0] instr_addr;
        logic [TRACE_DAW-1:0] data_addr;
        logic                 data_we;
        logic [31:0]          dec_end;
        logic [31:0]          req_time;
        logic [31:0]          gnt_time;
        logic [31:0]          rvalid_time;
        logic                 unmatched;
    } mem_trace_t;

    typedef struct packed {
        logic [TRACE_IDW-1:0] instruction;
        logic [TRACE_IAW-1:0] instr_addr;
        logic [31:0]          dec_end;
    } pend_t;

endpackage

// File: rtl/tracker_fifo.sv
// tracker_fifo: synchronous FIFO of pending load/store records; a pop frees a slot for a same-cycle push
module tracker_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // storage needs no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mem_tracker.sv
// mem_tracker: pairs IF-tracker load/store records with data-memory transactions and emits timed trace records (MEM_TRACKER_OVERFLOW_CNT_EN adds overflow_count)
module mem_tracker
    import gouram_trace_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = TRACE_IAW,
    parameter int INSTR_DATA_WIDTH = TRACE_IDW,
    parameter int DATA_ADDR_WIDTH  = TRACE_DAW,
    parameter int PENDING_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 counter,
    input  logic                        if_data_ready,
    input  logic [INSTR_DATA_WIDTH-1:0] if_instruction,
    input  logic [INSTR_ADDR_WIDTH-1:0] if_instr_addr,
    input  logic [31:0]                 dec_stage_end,
    input  logic                        data_req,
    input  logic                        data_gnt,
    input  logic                        data_rvalid,
    input  logic                        data_we,
    input  logic [DATA_ADDR_WIDTH-1:0]  data_addr,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output mem_trace_t                  trace_o,
    output logic                        overflow
`ifdef MEM_TRACKER_OVERFLOW_CNT_EN
    ,
    output logic [15:0]                 overflow_count
`endif
);
    mem_state_e state, next_state;
    mem_trace_t cur, rec;
    pend_t      head, push_entry;
    logic       start_req, accept_gnt, complete;
    logic       q_full, q_empty, push_drop, rec_drop;

    assign push_entry = '{instruction: if_instruction, instr_addr: if_instr_addr, dec_end: dec_stage_end};

    tracker_fifo #(
        .WIDTH($bits(pend_t)),
        .DEPTH(PENDING_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (if_data_ready),
        .pop  (accept_gnt),
        .wdata(push_entry),
        .rdata(head),
        .full (q_full),
        .empty(q_empty)
    );

    assign push_drop = if_data_ready & q_full & ~accept_gnt;
    assign rec_drop  = complete & trace_valid & ~trace_ready;

    // memory FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next state plus request/grant/completion events; a completing cycle may start the next request
    always_comb begin
        next_state = state;
        start_req  = 1'b0;
        accept_gnt = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                start_req  = data_req;
                accept_gnt = data_req & data_gnt;
                next_state = data_req ? (data_gnt ? WAIT_RVALID : WAIT_GNT) : IDLE;
            end
            WAIT_GNT: begin
                accept_gnt = data_gnt;
                next_state = data_gnt ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_RVALID: begin
                complete   = data_rvalid;
                start_req  = data_rvalid & data_req;
                accept_gnt = data_rvalid & data_req & data_gnt;
                next_state = !data_rvalid ? WAIT_RVALID :
                             data_req ? (data_gnt ? WAIT_RVALID : WAIT_GNT) : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // in-flight record: timestamps, address and the matched pending entry
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else begin
            if (start_req) cur.req_time <= counter;
            if (accept_gnt) begin
                cur.gnt_time    <= counter;
                cur.data_addr   <= data_addr;
                cur.data_we     <= data_we;
                cur.instruction <= q_empty ? '0 : head.instruction;
                cur.instr_addr  <= q_empty ? '0 : head.instr_addr;
                cur.dec_end     <= q_empty ? '0 : head.dec_end;
                cur.unmatched   <= q_empty;
            end
        end
    end

    // completed record stamped with the rvalid time
    always_comb begin
        rec             = cur;
        rec.rvalid_time = counter;
    end

    // output register: hold until accepted, drop a completion that finds it occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid <= 1'b0;
            trace_o     <= '0;
            overflow    <= 1'b0;
        end else begin
            overflow <= push_drop | rec_drop;
            if (complete && !rec_drop) begin
                trace_valid <= 1'b1;
                trace_o     <= rec;
            end else if (trace_valid && trace_ready) begin
                trace_valid <= 1'b0;
            end
        end
    end

`ifdef MEM_TRACKER_OVERFLOW_CNT_EN
    // saturating count of overflow pulses
    always_ff @(posedge clk) begin
        if (rst)                                    overflow_count <= '0;
        else if (overflow && overflow_count != '1)  overflow_count <= overflow_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_tracker.sv
// tb_mem_tracker: directed and randomized checks of mem_tracker against a queue-based reference model
module tb_mem_tracker;
    import gouram_trace_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] counter = '0;
    logic        if_data_ready = 1'b0;
    logic [31:0] if_instruction = '0;
    logic [15:0] if_instr_addr = '0;
    logic [31:0] dec_stage_end = '0;
    logic        data_req = 1'b0, data_gnt = 1'b0, data_rvalid = 1'b0, data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic        trace_valid, trace_ready = 1'b1, overflow;
    mem_trace_t  trace_o;
`ifdef MEM_TRACKER_OVERFLOW_CNT_EN
    logic [15:0] overflow_count;
`endif

    always #5 clk = ~clk;

    mem_tracker #(.PENDING_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .if_data_ready(if_data_ready), .if_instruction(if_instruction),
        .if_instr_addr(if_instr_addr), .dec_stage_end(dec_stage_end),
        .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_we(data_we), .data_addr(data_addr),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_o(trace_o), .overflow(overflow)
`ifdef MEM_TRACKER_OVERFLOW_CNT_EN
        , .overflow_count(overflow_count)
`endif
    );

    int total = 0;
    int fails = 0;
    logic [31:0] tcnt = '0;

    typedef struct {
        logic [31:0] ins;
        logic [15:0] ia;
        logic [31:0] de;
    } pend_s;

    pend_s      pq[$];
    bit         m_wait_gnt, m_wait_rv, m_valid, m_ovf;
    mem_trace_t m_cur, m_trace;
    int         m_cnt;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        pq.delete();
        m_wait_gnt = 0;
        m_wait_rv  = 0;
        m_valid    = 0;
        m_ovf      = 0;
        m_cur      = '0;
        m_trace    = '0;
        m_cnt      = 0;
    endfunction

    function automatic void model_grant();
        pend_s p;
        m_cur.gnt_time  = counter;
        m_cur.data_addr = data_addr;
        m_cur.data_we   = data_we;
        if (pq.size() > 0) begin
            p = pq.pop_front();
            m_cur.instruction = p.ins;
            m_cur.instr_addr  = p.ia;
            m_cur.dec_end     = p.de;
            m_cur.unmatched   = 1'b0;
        end else begin
            m_cur.instruction = '0;
            m_cur.instr_addr  = '0;
            m_cur.dec_end     = '0;
            m_cur.unmatched   = 1'b1;
        end
    endfunction

    function automatic void model_step();
        mem_trace_t rec;
        bit done, ovf;
        pend_s p;
        if (m_ovf && m_cnt < 65535) m_cnt++;
        ovf  = 0;
        done = m_wait_rv && data_rvalid;
        rec  = m_cur;
        rec.rvalid_time = counter;
        if ((!m_wait_gnt && !m_wait_rv) || done) begin
            m_wait_gnt = 0;
            m_wait_rv  = 0;
            if (data_req) begin
                m_cur.req_time = counter;
                if (data_gnt) begin
                    model_grant();
                    m_wait_rv = 1;
                end else m_wait_gnt = 1;
            end
        end else if (m_wait_gnt && data_gnt) begin
            model_grant();
            m_wait_gnt = 0;
            m_wait_rv  = 1;
        end
        if (if_data_ready) begin
            if (pq.size() < D) begin
                p.ins = if_instruction;
                p.ia  = if_instr_addr;
                p.de  = dec_stage_end;
                pq.push_back(p);
            end else ovf = 1;
        end
        if (done) begin
            if (m_valid && !trace_ready) ovf = 1;
            else begin
                m_valid = 1;
                m_trace = rec;
            end
        end else if (m_valid && trace_ready) m_valid = 0;
        m_ovf = ovf;
    endfunction

    task automatic cycle();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        chk("trace_valid", trace_valid, m_valid);
        chk("trace_o", trace_o, m_trace);
        chk("overflow", overflow, m_ovf);
`ifdef MEM_TRACKER_OVERFLOW_CNT_EN
        chk("overflow_count", overflow_count, m_cnt[15:0]);
`endif
        if_data_ready = 1'b0;
        tcnt++;
        counter = tcnt;
    endtask

    task automatic step(input bit req, input bit gnt, input bit rv, input bit rdy);
        data_req    = req;
        data_gnt    = gnt;
        data_rvalid = rv;
        trace_ready = rdy;
        cycle();
    endtask

    task automatic push_next(input logic [31:0] ins, input logic [15:0] ia, input logic [31:0] de);
        if_data_ready  = 1'b1;
        if_instruction = ins;
        if_instr_addr  = ia;
        dec_stage_end  = de;
    endtask

    task automatic set_time(input logic [31:0] t);
        tcnt    = t;
        counter = t;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_trace", trace_o, '0);
        rst = 1'b0;

        // single load, grant with request
        data_addr = 32'h1000_0010;
        push_next(32'h0001_2083, 16'h0040, 32'd50);
        step(0, 0, 0, 1);
        set_time(100);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("s1_valid", trace_valid, 1'b1);
        chk("s1_ins", trace_o.instruction, 32'h0001_2083);
        chk("s1_gnt", trace_o.gnt_time, 32'd100);
        chk("s1_rv", trace_o.rvalid_time, 32'd102);
        chk("s1_unm", trace_o.unmatched, 1'b0);
        step(0, 0, 0, 1);

        // grant delayed through WAIT_GNT
        push_next(32'h0041_2023, 16'h0044, 32'd7);
        data_we = 1'b1;
        step(0, 0, 0, 1);
        set_time(10);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        chk("s2_req", trace_o.req_time, 32'd10);
        chk("s2_gnt", trace_o.gnt_time, 32'd13);
        chk("s2_rv", trace_o.rvalid_time, 32'd14);
        chk("s2_we", trace_o.data_we, 1'b1);
        data_we = 1'b0;

        // back-to-back transactions
        push_next(32'h0000_A003, 16'h0100, 32'd1);
        step(0, 0, 0, 1);
        push_next(32'h0000_B003, 16'h0104, 32'd2);
        step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        chk("s3_first", trace_o.instruction, 32'h0000_A003);
        step(0, 0, 1, 1);
        chk("s3_second", trace_o.instruction, 32'h0000_B003);
        chk("s3_noovf", overflow, 1'b0);
        step(0, 0, 0, 1);

        // consumer stalled through two completions
        push_next(32'h0000_C003, 16'h0200, 32'd3);
        step(0, 0, 0, 0);
        push_next(32'h0000_D003, 16'h0204, 32'd4);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("s4_held", trace_o.instruction, 32'h0000_C003);
        chk("s4_ovf", overflow, 1'b1);
        step(0, 0, 0, 0);
        chk("s4_pulse", overflow, 1'b0);
`ifdef MEM_TRACKER_OVERFLOW_CNT_EN
        chk("s4_cnt", overflow_count, 16'd1);
`endif
        step(0, 0, 0, 1);
        chk("s4_drain", trace_valid, 1'b0);

        // grant with an empty queue
        step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        chk("s5_unm", trace_o.unmatched, 1'b1);
        chk("s5_ins", trace_o.instruction, 32'd0);

        // reset in WAIT_RVALID with a queued entry
        push_next(32'h0000_E003, 16'h0300, 32'd5);
        step(0, 0, 0, 1);
        push_next(32'h0000_F003, 16'h0304, 32'd6);
        step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        rst = 1'b1;
        step(0, 0, 0, 1);
        rst = 1'b0;
        chk("s6_valid", trace_valid, 1'b0);
        push_next(32'h0001_1003, 16'h0308, 32'd8);
        step(0, 0, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        chk("s6_ins", trace_o.instruction, 32'h0001_1003);
        chk("s6_unm", trace_o.unmatched, 1'b0);

        // queue full: fifth push dropped
        for (int i = 0; i < D + 1; i++) begin
            push_next(32'h100 + i, 16'(i), 32'(i));
            step(0, 0, 0, 1);
        end
        chk("full_ovf", overflow, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) push_next($urandom, 16'($urandom), $urandom);
            data_addr = $urandom;
            data_we   = 1'($urandom);
            if ($urandom_range(0, 40) == 0) set_time($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
